uart_tx_fifo_core: RTL

- Buffered UART transmitter. Sits directly downstream of the I/O device's address decode and drives the board TX pin.
- Accepts byte writes on the shared peripheral bus (en / write_enable / addr / data_in) and queues them in a small FIFO.
- Serialises each byte as 8N1, LSB first, at a fixed baud divisor.
- Exports a busy flag for the I/O device's status register at offset 0x3.

---
 rtl/uart_tx_fifo_core_pkg.sv | 31 +++
 rtl/uart_tx_fifo_core_byte_fifo.sv | 55 +++++
 rtl/uart_tx_fifo_core.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/uart_tx_fifo_core_pkg.sv
// Shared constants and types for the buffered UART transmitter.
// Optional 8E1 framing is enabled with the UART_TX_PARITY_EN macro.
package uart_tx_fifo_core_pkg;

    localparam logic [3:0]  UART_TX_DATA_ADDR    = 4'h2;
    localparam int unsigned CLK_HZ               = 12_000_000;
    localparam int unsigned BAUD                 = 115_200;
    localparam int unsigned DEFAULT_CLKS_PER_BIT = CLK_HZ / BAUD;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_e;

    function automatic logic even_parity(input logic [7:0] b);
        return ^b;
    endfunction
`else
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } tx_state_e;
`endif

endpackage

// File: rtl/uart_tx_fifo_core_byte_fifo.sv
// Byte FIFO: storage, wrapping pointers, occupancy count, full/empty flags.
// Push is refused when full judged on the pre-edge count, even if a pop coincides.
module uart_tx_fifo_core_byte_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int unsigned AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q;
    logic [AW-1:0]    rptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign count_o = count_q;
    assign rdata_o = mem_q[rptr_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= wdata_i;
    end

endmodule

// File: rtl/uart_tx_fifo_core.sv
// Buffered UART transmitter: bus byte writes queue into a FIFO, serialised 8N1 LSB first.
// Define UART_TX_PARITY_EN for 8E1 framing (even parity bit between data and stop).
module uart_tx_fifo_core
    import uart_tx_fifo_core_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int unsigned FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [2:0]  write_enable,
    input  logic [23:0] addr,
    input  logic [31:0] data_in,
    output logic        uart_txd,
    output logic        uart_tx_busy,
    output logic        uart_tx_idle
);

    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

    tx_state_e                   state_q;
    logic [15:0]                 baud_cnt_q;
    logic [2:0]                  bit_cnt_q;
    logic [7:0]                  shift_q;
    logic                        txd_q;
`ifdef UART_TX_PARITY_EN
    logic                        parity_q;
`endif

    logic                        push;
    logic                        pop;
    logic                        baud_done;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic [7:0]                  fifo_rdata;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic                        unused_ok;

    assign push      = en && write_enable[2] && (addr[3:0] == UART_TX_DATA_ADDR);
    assign baud_done = (baud_cnt_q == BAUD_LAST);
    // Pop from IDLE, or on the last stop-bit cycle so frames run back to back.
    assign pop       = !fifo_empty &&
                       ((state_q == ST_IDLE) || ((state_q == ST_STOP) && baud_done));
    assign unused_ok = ^{addr[23:4], data_in[31:8], write_enable[1:0], fifo_count};

    uart_tx_fifo_core_byte_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (data_in[7:0]),
        .rdata_o (fifo_rdata),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            txd_q      <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            baud_cnt_q <= baud_done ? '0 : baud_cnt_q + 1'b1;
            case (state_q)
                ST_IDLE: begin
                    baud_cnt_q <= '0;
                    txd_q      <= 1'b1;
                    if (pop) begin
                        shift_q  <= fifo_rdata;
                        txd_q    <= 1'b0;
                        state_q  <= ST_START;
`ifdef UART_TX_PARITY_EN
                        parity_q <= even_parity(fifo_rdata);
`endif
                    end
                end
                ST_START: begin
                    if (baud_done) begin
                        txd_q     <= shift_q[0];
                        shift_q   <= {1'b0, shift_q[7:1]};
                        bit_cnt_q <= '0;
                        state_q   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (baud_done) begin
                        if (bit_cnt_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            txd_q   <= parity_q;
                            state_q <= ST_PARITY;
`else
                            txd_q   <= 1'b1;
                            state_q <= ST_STOP;
`endif
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                            txd_q     <= shift_q[0];
                            shift_q   <= {1'b0, shift_q[7:1]};
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (baud_done) begin
                        txd_q   <= 1'b1;
                        state_q <= ST_STOP;
                    end
                end
`endif
                ST_STOP: begin
                    if (baud_done) begin
                        if (pop) begin
                            shift_q  <= fifo_rdata;
                            txd_q    <= 1'b0;
                            state_q  <= ST_START;
`ifdef UART_TX_PARITY_EN
                            parity_q <= even_parity(fifo_rdata);
`endif
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    txd_q   <= 1'b1;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign uart_txd     = txd_q;
    assign uart_tx_busy = fifo_full;
    assign uart_tx_idle = (state_q == ST_IDLE) && fifo_empty;

endmodule
